// File: rtl/bp_common_pkg.sv
// Shared definitions for the BlackParrot I/O responders: access sizes,
// command/response field widths and CLINT register offsets.
package bp_common_pkg;

    localparam int bp_paddr_width_gp    = 56;
    localparam int bp_data_width_gp     = 64;
    localparam int bp_mem_size_width_gp = 2;

    typedef enum logic [1:0] {
        e_size_1B = 2'd0,
        e_size_2B = 2'd1,
        e_size_4B = 2'd2,
        e_size_8B = 2'd3
    } bp_mem_size_e;

    localparam logic [23:0] clint_mipi_offset_gp     = 24'h00_0000;
    localparam logic [23:0] clint_mtimecmp_offset_gp = 24'h00_4000;
    localparam logic [23:0] clint_mtime_offset_gp    = 24'h00_bff8;

    typedef enum logic {
        e_clint_idle = 1'b0,
        e_clint_resp = 1'b1
    } bp_clint_state_e;

endpackage

// File: rtl/bp_clint_mtime.sv
// 64b machine timer: ticks when enabled, writable per 32b half; a write
// in the same cycle suppresses the tick so the written value lands exactly.
module bp_clint_mtime (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        tick_i,
    input  logic [1:0]  we_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] mtime_o
);

    logic [63:0] r_mtime;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_mtime <= '0;
        end else if (|we_i) begin
            // the unwritten half holds; no carry across halves
            if (we_i[0]) r_mtime[31:0]  <= wdata_i[31:0];
            if (we_i[1]) r_mtime[63:32] <= wdata_i[63:32];
        end else if (tick_i) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    assign mtime_o = r_mtime;

endmodule

// File: rtl/bp_clint_responder.sv
// CLINT device responder: decodes uncached loads/stores to mipi, mtimecmp
// and mtime, and drives per-hart software/timer interrupts from registers.
module bp_clint_responder
    import bp_common_pkg::*;
#(
    parameter int num_core_p    = 1,
    parameter int paddr_width_p = bp_paddr_width_gp,
    parameter int data_width_p  = bp_data_width_gp
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     cmd_v_i,
    output logic                     cmd_ready_o,
    input  logic [paddr_width_p-1:0] cmd_addr_i,
    input  logic                     cmd_we_i,
    input  logic [1:0]               cmd_size_i,
    input  logic [data_width_p-1:0]  cmd_data_i,
    output logic                     resp_v_o,
    input  logic                     resp_ready_i,
    output logic [data_width_p-1:0]  resp_data_o,
    output logic                     resp_err_o,
    input  logic                     mtime_tick_i,
    output logic [num_core_p-1:0]    soft_irq_o,
    output logic [num_core_p-1:0]    timer_irq_o
);

    bp_clint_state_e r_state, w_state_n;

    logic [num_core_p-1:0][63:0] r_mtimecmp;
    logic [num_core_p-1:0]       r_mipi;
    logic [63:0]                 r_resp_data;
    logic                        r_resp_err;
    logic [63:0]                 w_mtime;

    logic [23:0] w_off;
    logic [11:0] w_mipi_idx, w_cmp_idx;
    logic        w_sz4_ok, w_sz64_ok, w_full, w_hi;
    logic        w_hit_mipi, w_hit_cmp, w_hit_mtime, w_err;
    logic        w_accept, w_wr;
    logic [1:0]  w_half_we, w_mtime_we;
    logic [63:0] w_wdata, w_rdata, w_word, w_cmp_sel;
    logic        w_mipi_sel;
    logic        w_unused;

    assign w_off      = cmd_addr_i[23:0];
    assign w_unused   = ^cmd_addr_i[paddr_width_p-1:24];
    assign w_mipi_idx = w_off[13:2];
    assign w_cmp_idx  = {1'b0, w_off[13:3]};

    // mipi: 4B aligned only; mtimecmp/mtime: aligned 8B or either 4B half
    assign w_full    = (cmd_size_i == e_size_8B);
    assign w_hi      = w_off[2];
    assign w_sz4_ok  = (cmd_size_i == e_size_4B) && (w_off[1:0] == 2'b00);
    assign w_sz64_ok = (w_full && (w_off[2:0] == 3'b000)) || w_sz4_ok;

    assign w_hit_mipi  = (w_off[23:14] == clint_mipi_offset_gp[23:14]) && w_sz4_ok
                         && (w_mipi_idx < 12'(num_core_p));
    assign w_hit_cmp   = (w_off[23:14] == clint_mtimecmp_offset_gp[23:14]) && w_sz64_ok
                         && (w_cmp_idx < 12'(num_core_p));
    assign w_hit_mtime = (w_off[23:3] == clint_mtime_offset_gp[23:3]) && w_sz64_ok;
    assign w_err       = !(w_hit_mipi || w_hit_cmp || w_hit_mtime);

    assign w_accept   = cmd_v_i && (r_state == e_clint_idle);
    assign w_wr       = w_accept && cmd_we_i && !w_err;
    assign w_half_we  = w_full ? 2'b11 : {w_hi, !w_hi};
    assign w_wdata    = w_full ? cmd_data_i : {2{cmd_data_i[31:0]}};
    assign w_mtime_we = (w_wr && w_hit_mtime) ? w_half_we : 2'b00;

    always_comb begin
        w_rdata    = '0;
        w_word     = '0;
        w_cmp_sel  = '0;
        w_mipi_sel = 1'b0;
        for (int i = 0; i < num_core_p; i++) begin
            if (w_mipi_idx == 12'(i)) w_mipi_sel = r_mipi[i];
            if (w_cmp_idx == 12'(i))  w_cmp_sel  = r_mtimecmp[i];
        end
        w_word = w_hit_mtime ? w_mtime : w_cmp_sel;
        if (w_hit_mipi)
            w_rdata = {63'b0, w_mipi_sel};
        else if (w_hit_cmp || w_hit_mtime)
            w_rdata = w_full ? w_word : {32'b0, (w_hi ? w_word[63:32] : w_word[31:0])};
    end

    bp_clint_mtime u_mtime (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .tick_i    (mtime_tick_i),
        .we_i      (w_mtime_we),
        .wdata_i   (w_wdata),
        .mtime_o   (w_mtime)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_mtimecmp <= '1;
            r_mipi     <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < num_core_p; i++) begin
                if (w_hit_cmp && (w_cmp_idx == 12'(i))) begin
                    if (w_half_we[0]) r_mtimecmp[i][31:0]  <= w_wdata[31:0];
                    if (w_half_we[1]) r_mtimecmp[i][63:32] <= w_wdata[63:32];
                end
                if (w_hit_mipi && (w_mipi_idx == 12'(i)))
                    r_mipi[i] <= cmd_data_i[0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else if (w_accept) begin
            r_resp_data <= (cmd_we_i || w_err) ? 64'd0 : w_rdata;
            r_resp_err  <= w_err;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= e_clint_idle;
        else            r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            e_clint_idle: if (cmd_v_i)      w_state_n = e_clint_resp;
            e_clint_resp: if (resp_ready_i) w_state_n = e_clint_idle;
            default:                        w_state_n = e_clint_idle;
        endcase
    end

    assign cmd_ready_o = (r_state == e_clint_idle);
    assign resp_v_o    = (r_state == e_clint_resp);
    assign resp_data_o = r_resp_data;
    assign resp_err_o  = r_resp_err;
    assign soft_irq_o  = r_mipi;

    for (genvar g = 0; g < num_core_p; g++) begin : g_hart
        assign timer_irq_o[g] = (w_mtime >= r_mtimecmp[g]);
    end

endmodule

// File: tb/tb_bp_clint_responder.sv
// Directed + randomized bench for bp_clint_responder against an address-range
// reference model of the CLINT register file.
module tb_bp_clint_responder;

    localparam int NC = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_v = 1'b0;
    logic          cmd_ready;
    logic [55:0]   cmd_addr = '0;
    logic          cmd_we = 1'b0;
    logic [1:0]    cmd_size = 2'd3;
    logic [63:0]   cmd_data = '0;
    logic          resp_v;
    logic          resp_ready = 1'b0;
    logic [63:0]   resp_data;
    logic          resp_err;
    logic          tick = 1'b0;
    logic [NC-1:0] soft_irq, timer_irq;

    bp_clint_responder #(.num_core_p(NC), .paddr_width_p(56), .data_width_p(64)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .cmd_v_i      (cmd_v),
        .cmd_ready_o  (cmd_ready),
        .cmd_addr_i   (cmd_addr),
        .cmd_we_i     (cmd_we),
        .cmd_size_i   (cmd_size),
        .cmd_data_i   (cmd_data),
        .resp_v_o     (resp_v),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_err_o   (resp_err),
        .mtime_tick_i (tick),
        .soft_irq_o   (soft_irq),
        .timer_irq_o  (timer_irq)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nfail = 0;

    longint unsigned m_mtime;
    longint unsigned m_cmp [NC];
    bit              m_mipi[NC];
    bit              m_pend;
    logic [63:0]     m_rdata;
    bit              m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mtime = 0;
        m_pend  = 0;
        m_rdata = 0;
        m_err   = 0;
        for (int i = 0; i < NC; i++) begin
            m_cmp[i]  = 64'hFFFF_FFFF_FFFF_FFFF;
            m_mipi[i] = 0;
        end
    endtask

    // Executes one accepted command on the model, using pre-edge register values.
    task automatic model_cmd(input logic [55:0] a, input bit we, input logic [1:0] sz,
                             input logic [63:0] d, output bit mt_wr);
        int unsigned     off;
        int unsigned     nb;
        int unsigned     hart;
        int              kind;
        bit              ok;
        bit              hi;
        longint unsigned v;
        off   = a[23:0];
        nb    = 1 << sz;
        hart  = 0;
        kind  = 0;
        ok    = 0;
        mt_wr = 0;
        if (off < 'h4000) begin
            hart = off / 4;
            kind = 1;
            ok   = (nb == 4) && (off % 4 == 0) && (hart < NC);
        end else if (off < 'h8000) begin
            hart = (off - 'h4000) / 8;
            kind = 2;
            ok   = (hart < NC) && (((nb == 8) && (off % 8 == 0)) || ((nb == 4) && (off % 4 == 0)));
        end else if (off == 'hbff8 || off == 'hbffc) begin
            kind = 3;
            ok   = (nb == 4) || ((nb == 8) && (off == 'hbff8));
        end
        m_err   = !ok;
        m_rdata = 0;
        if (!ok) return;
        if (kind == 1) begin
            if (we) m_mipi[hart] = d[0];
            else    m_rdata = {63'b0, m_mipi[hart]};
            return;
        end
        v  = (kind == 2) ? m_cmp[hart] : m_mtime;
        hi = (off % 8 == 4);
        if (!we) begin
            m_rdata = (nb == 8) ? v : (hi ? (v >> 32) : (v & 64'hFFFF_FFFF));
        end else begin
            if (nb == 8) v = d;
            else if (hi) v = (v & 64'hFFFF_FFFF) | (longint'(d[31:0]) << 32);
            else         v = (v & 64'hFFFF_FFFF_0000_0000) | longint'(d[31:0]);
            if (kind == 2) m_cmp[hart] = v;
            else begin m_mtime = v; mt_wr = 1; end
        end
    endtask

    task automatic check_all();
        chk("cmd_ready", {63'b0, cmd_ready}, {63'b0, !m_pend});
        chk("resp_v", {63'b0, resp_v}, {63'b0, m_pend});
        if (m_pend) begin
            chk("resp_data", resp_data, m_rdata);
            chk("resp_err", {63'b0, resp_err}, {63'b0, m_err});
        end
        for (int i = 0; i < NC; i++) begin
            chk("soft_irq", {63'b0, soft_irq[i]}, {63'b0, m_mipi[i]});
            chk("timer_irq", {63'b0, timer_irq[i]}, {63'b0, (m_mtime >= m_cmp[i])});
        end
    endtask

    // One clock: advance the model by the inputs seen at the edge, then check.
    task automatic cycle();
        bit mt_wr;
        @(posedge clk);
        mt_wr = 0;
        if (!m_pend && cmd_v) begin
            model_cmd(cmd_addr, cmd_we, cmd_size, cmd_data, mt_wr);
            m_pend = 1;
        end else if (m_pend && resp_ready) begin
            m_pend = 0;
        end
        if (tick && !mt_wr) m_mtime++;
        #1;
        check_all();
    endtask

    task automatic send(input logic [55:0] a, input bit we, input logic [1:0] sz, input logic [63:0] d);
        cmd_v = 1; cmd_addr = a; cmd_we = we; cmd_size = sz; cmd_data = d;
        cycle();
        cmd_v = 0;
    endtask

    task automatic finish_resp(input int stall);
        resp_ready = 0;
        for (int k = 0; k < stall; k++) cycle();
        resp_ready = 1;
        cycle();
        resp_ready = 0;
    endtask

    logic [23:0] offs [12];

    initial begin
        offs = '{24'h0000, 24'h0004, 24'h0001, 24'h4000, 24'h4004, 24'h4002, 24'h4008,
                 24'hbff8, 24'hbffc, 24'hbff0, 24'h8000, 24'h0002};
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        #1 check_all();

        // reset value of mtimecmp[0]
        send(56'h0200_4000, 0, 2'd3, 0);
        chk("cmp_reset", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("cmp_reset_err", {63'b0, resp_err}, 64'd0);
        finish_resp(0);

        // mipi set, readback, then clear with bit0=0
        send(56'h0200_0000, 1, 2'd2, 64'h1);
        chk("soft_set", {63'b0, soft_irq[0]}, 64'd1);
        finish_resp(0);
        send(56'h0200_0000, 0, 2'd2, 0);
        chk("mipi_load", resp_data, 64'h1);
        finish_resp(1);
        send(56'h0200_0000, 1, 2'd2, 64'h2);
        chk("soft_clr", {63'b0, soft_irq[0]}, 64'd0);
        finish_resp(0);

        // timer compare against a running mtime
        tick = 1;
        send(56'h0200_4000, 1, 2'd3, 64'd10);
        finish_resp(0);
        repeat (14) cycle();

        // store to mtime wins over a concurrent tick, then wraps
        send(56'h0200_bff8, 1, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mtime_wr_wins", {63'b0, timer_irq[0]}, 64'd1);
        resp_ready = 1;
        cycle();
        resp_ready = 0;
        chk("mtime_wrap", {63'b0, timer_irq[0]}, 64'd0);
        tick = 0;

        // 4B high-half load of mtime
        send(56'h0200_bff8, 1, 2'd3, 64'h1_0000_0005);
        finish_resp(0);
        send(56'h0200_bffc, 0, 2'd2, 0);
        chk("mtime_hi", resp_data, 64'h1);
        finish_resp(0);

        // faults, each held 3 cycles without resp_ready
        send(56'h0200_4004, 0, 2'd3, 0);
        chk("flt_misalign_err", {63'b0, resp_err}, 64'd1);
        chk("flt_misalign_data", resp_data, 64'd0);
        finish_resp(3);
        send(56'h0200_0004, 0, 2'd2, 0);
        chk("flt_hart_err", {63'b0, resp_err}, 64'd1);
        finish_resp(3);
        send(56'h0200_8000, 0, 2'd3, 0);
        chk("flt_unmapped_err", {63'b0, resp_err}, 64'd1);
        finish_resp(3);
        send(56'h0200_4004, 1, 2'd3, 64'h1234);
        finish_resp(0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            cmd_v      = ($urandom_range(0, 2) != 0);
            cmd_addr   = {32'h0000_0200, offs[$urandom_range(0, 11)]};
            cmd_we     = $urandom_range(0, 1);
            cmd_size   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) cmd_size = 2'd2;
            cmd_data   = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) cmd_data = {32'h0, 32'($urandom_range(0, 40))};
            tick       = $urandom_range(0, 1);
            resp_ready = $urandom_range(0, 1);
            cycle();
        end
        cmd_v = 0; resp_ready = 0; tick = 0;

        // reset while a response is pending discards it and restores reset values
        send(56'h0200_0000, 1, 2'd2, 64'h1);
        #2 reset_n = 0;
        #1;
        model_reset();
        chk("rst_resp_v", {63'b0, resp_v}, 64'd0);
        chk("rst_soft", {63'b0, soft_irq[0]}, 64'd0);
        @(posedge clk);
        #1 reset_n = 1;
        #1 check_all();
        send(56'h0200_bff8, 0, 2'd3, 0);
        chk("rst_mtime", resp_data, 64'd0);
        finish_resp(0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
